// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit with byte lanes, load extension, wait states, flush and bus timeout.
module lsu_mem_stage #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_mem_i,
  input  logic              write_mem_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] result_i,
  input  logic [31:0]       store_data_i,
  input  logic              flush_i,
  input  logic              ready_i,
  input  logic [31:0]       rdata_i,
  output logic              ce_o,
  output logic              we_o,
  output logic [3:0]        be_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [31:0]       wdata_o,
  output logic [31:0]       load_data_o,
  output logic              done_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              bus_err_o
);
  typedef enum logic [1:0] {IDLE, BUS, DONE} state_e;
  state_e            state_q, state_d;
  logic              ce_q, ce_d, we_q, we_d, done_q, done_d, mis_q, mis_d, err_q, err_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d, ld_q, ld_d;
  logic [TO_W-1:0]   timer_q, timer_d;
  logic [1:0]        a_q, a_d;
  logic [2:0]        f3_q, f3_d;
  logic              req, mis, to_hit;
  logic [1:0]        a, sz;
  logic [3:0]        be_req;
  logic [31:0]       wd_req, sh, ld_ext;
  assign req    = read_mem_i | write_mem_i;
  assign a      = result_i[1:0];
  assign sz     = funct3_i[1:0];
  // size code 3 falls into the word case via sz[1]
  assign mis    = (sz == 2'd1 && a[0]) || (sz[1] && a != 2'd0);
  assign be_req = sz == 2'd0 ? 4'b0001 << a : sz == 2'd1 ? 4'b0011 << a : 4'hf;
  assign wd_req = sz == 2'd0 ? {4{store_data_i[7:0]}} : sz == 2'd1 ? {2{store_data_i[15:0]}} : store_data_i;
  assign sh     = rdata_i >> {a_q, 3'b000};
  assign ld_ext = f3_q[1:0] == 2'd0 ? {{24{~f3_q[2] & sh[7]}}, sh[7:0]} :
                  f3_q[1:0] == 2'd1 ? {{16{~f3_q[2] & sh[15]}}, sh[15:0]} : sh;
  assign to_hit = TIMEOUT != 0 && timer_q == TO_W'(TIMEOUT - 1);
  assign stall_o = (state_q == IDLE && req && !flush_i) || state_q == BUS;
  always_comb begin
    state_d = state_q;
    ce_d    = ce_q;
    we_d    = we_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ld_d    = ld_q;
    timer_d = timer_q;
    a_d     = a_q;
    f3_d    = f3_q;
    done_d  = 1'b0;
    mis_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (req && !flush_i) begin
        if (mis) begin
          state_d = DONE;
          done_d  = 1'b1;
          mis_d   = 1'b1;
        end else begin
          state_d = BUS;
          ce_d    = 1'b1;
          we_d    = !read_mem_i;
          be_d    = be_req;
          addr_d  = {result_i[ADDR_W-1:2], 2'b00};
          wdata_d = read_mem_i ? 32'h0 : wd_req;
          timer_d = '0;
          a_d     = a;
          f3_d    = funct3_i;
        end
      end
      BUS: begin
        if (flush_i || ready_i || to_hit) begin
          state_d = flush_i ? IDLE : DONE;
          ce_d    = 1'b0;
          we_d    = 1'b0;
          be_d    = '0;
          addr_d  = '0;
          wdata_d = '0;
          done_d  = !flush_i;
          err_d   = !flush_i && !ready_i;
          ld_d    = !flush_i && ready_i && !we_q ? ld_ext : ld_q;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      timer_q <= '0;
      a_q     <= '0;
      f3_q    <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ld_q    <= ld_d;
      timer_q <= timer_d;
      a_q     <= a_d;
      f3_q    <= f3_d;
      done_q  <= done_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end
  assign ce_o        = ce_q;
  assign we_o        = we_q;
  assign be_o        = be_q;
  assign data_addr_o = addr_q;
  assign wdata_o     = wdata_q;
  assign load_data_o = ld_q;
  assign done_o      = done_q;
  assign misalign_o  = mis_q;
  assign bus_err_o   = err_q;
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: directed bench for lsu_mem_stage covering sizes, extension, wait states, misalign, timeout, flush, reset.
module tb_lsu_mem_stage;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        read_mem_i = 0, write_mem_i = 0, flush_i = 0, ready_i = 0;
  logic [2:0]  funct3_i = 0;
  logic [31:0] result_i = 0, store_data_i = 0, rdata_i = 0;
  logic        ce_o, we_o, done_o, stall_o, misalign_o, bus_err_o;
  logic [3:0]  be_o;
  logic [31:0] data_addr_o, wdata_o, load_data_o;
  int          n_chk = 0, n_fail = 0;
  lsu_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .read_mem_i(read_mem_i), .write_mem_i(write_mem_i),
    .funct3_i(funct3_i), .result_i(result_i), .store_data_i(store_data_i), .flush_i(flush_i),
    .ready_i(ready_i), .rdata_i(rdata_i), .ce_o(ce_o), .we_o(we_o), .be_o(be_o),
    .data_addr_o(data_addr_o), .wdata_o(wdata_o), .load_data_o(load_data_o), .done_o(done_o),
    .stall_o(stall_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] sd);
    read_mem_i = rd; write_mem_i = wr; funct3_i = f3; result_i = ad; store_data_i = sd;
  endtask
  // request cycle, 'waits' bus cycles with ready low, then one with ready high
  task automatic access(input string tag, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] ad, input logic [31:0] sd, input logic [31:0] rdat,
                        input int waits, input logic [3:0] ebe, input logic [31:0] ewd, input logic [31:0] eld);
    int dones = 0;
    req(rd, wr, f3, ad, sd);
    ready_i = 0;
    #1 chk({tag, ":stall_req"}, stall_o, 1);
    chk({tag, ":ce_req"}, ce_o, 0);
    step();
    req(0, 0, 0, 0, 0);
    for (int i = 0; i <= waits; i++) begin
      ready_i = (i == waits);
      rdata_i = (i == waits) ? rdat : 32'h0;
      #1 chk({tag, ":ce"}, ce_o, 1);
      chk({tag, ":we"}, we_o, !rd);
      chk({tag, ":be"}, be_o, ebe);
      chk({tag, ":addr"}, data_addr_o, {ad[31:2], 2'b00});
      chk({tag, ":stall_bus"}, stall_o, 1);
      if (!rd) chk({tag, ":wdata"}, wdata_o, ewd);
      if (done_o) dones++;
      step();
    end
    ready_i = 0;
    if (done_o) dones++;
    chk({tag, ":done_cnt"}, dones, 1);
    chk({tag, ":ce_off"}, ce_o, 0);
    chk({tag, ":be_off"}, be_o, 0);
    chk({tag, ":stall_done"}, stall_o, 0);
    chk({tag, ":err"}, {misalign_o, bus_err_o}, 0);
    chk({tag, ":load"}, load_data_o, eld);
    step();
    chk({tag, ":done_clr"}, done_o, 0);
  endtask
  task automatic misal(input string tag, input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] ad);
    req(rd, wr, f3, ad, 32'h0);
    #1 chk({tag, ":stall"}, stall_o, 1);
    step();
    req(0, 0, 0, 0, 0);
    #1 chk({tag, ":done"}, {done_o, misalign_o, bus_err_o}, 3'b110);
    chk({tag, ":ce"}, ce_o, 0);
    chk({tag, ":stall_done"}, stall_o, 0);
    step();
    chk({tag, ":clr"}, {done_o, misalign_o, ce_o}, 0);
  endtask
  initial begin
    int cnt;
    #12;
    chk("rst:bus", {ce_o, we_o, be_o}, 0);
    chk("rst:addr", data_addr_o, 0);
    chk("rst:load", load_data_o, 0);
    chk("rst:flags", {done_o, misalign_o, bus_err_o, stall_o}, 0);
    rst_n = 1;
    step();
    access("lw",   1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, 4'hF, 0, 32'hDEADBEEF);
    access("lb",   1, 0, 3'd0, 32'h103, 0, 32'h80112233, 0, 4'h8, 0, 32'hFFFFFF80);
    access("lbu",  1, 0, 3'd4, 32'h103, 0, 32'h80112233, 0, 4'h8, 0, 32'h00000080);
    access("lh",   1, 0, 3'd1, 32'h102, 0, 32'h80011234, 0, 4'hC, 0, 32'hFFFF8001);
    access("lhu",  1, 0, 3'd5, 32'h102, 0, 32'h80011234, 0, 4'hC, 0, 32'h00008001);
    access("sh",   0, 1, 3'd1, 32'h202, 32'h0000ABCD, 32'h0, 3, 4'hC, 32'hABCDABCD, 32'h00008001);
    access("sb",   0, 1, 3'd0, 32'h001, 32'h12345678, 32'h0, 1, 4'h2, 32'h78787878, 32'h00008001);
    access("sw",   0, 1, 3'd2, 32'h008, 32'hCAFEF00D, 32'h0, 0, 4'hF, 32'hCAFEF00D, 32'h00008001);
    access("rdwr", 1, 1, 3'd2, 32'h104, 32'h0, 32'h11223344, 0, 4'hF, 0, 32'h11223344);
    access("f3_3", 1, 0, 3'd3, 32'h108, 32'h0, 32'h55667788, 0, 4'hF, 0, 32'h55667788);
    misal("mis_lw", 1, 0, 3'd2, 32'h101);
    misal("mis_sh", 0, 1, 3'd1, 32'h203);
    misal("mis_w2", 1, 0, 3'd2, 32'h102);
    // flush while idle: request must not be accepted
    req(1, 0, 3'd2, 32'h500, 0);
    flush_i = 1;
    #1 chk("fidle:stall", stall_o, 0);
    step();
    req(0, 0, 0, 0, 0);
    flush_i = 0;
    chk("fidle:ce", {ce_o, done_o}, 0);
    // timeout with ready held low
    req(1, 0, 3'd2, 32'h300, 0);
    step();
    req(0, 0, 0, 0, 0);
    cnt = 0;
    while (ce_o && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to:cycles", cnt, 15);
    chk("to:flags", {done_o, bus_err_o, misalign_o, ce_o}, 4'b1100);
    chk("to:load", load_data_o, 32'h55667788);
    step();
    chk("to:clr", {done_o, bus_err_o}, 0);
    // flush in second bus cycle wins over ready
    req(1, 0, 3'd2, 32'h400, 0);
    step();
    req(0, 0, 0, 0, 0);
    chk("fl:ce1", ce_o, 1);
    step();
    ready_i = 1; rdata_i = 32'h12345678; flush_i = 1;
    #1 chk("fl:ce2", ce_o, 1);
    step();
    chk("fl:after", {ce_o, done_o, stall_o}, 0);
    chk("fl:load", load_data_o, 32'h55667788);
    ready_i = 0; flush_i = 0;
    step();
    chk("fl:nodone", done_o, 0);
    // asynchronous reset in the middle of a bus cycle
    req(0, 1, 3'd2, 32'h600, 32'hA5A5A5A5);
    step();
    req(0, 0, 0, 0, 0);
    chk("rmid:ce", ce_o, 1);
    #1 rst_n = 0;
    #1 chk("rmid:bus", {ce_o, we_o, be_o, stall_o}, 0);
    chk("rmid:addr", data_addr_o, 0);
    chk("rmid:wdata", wdata_o, 0);
    chk("rmid:load", load_data_o, 0);
    step();
    rst_n = 1;
    step();
    chk("rmid:idle", {ce_o, done_o}, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
